// File: rtl/mem_load_unit.sv
// mem_load_unit: issues word reads to data memory, extracts/extends byte/half/word, pulses the data register load
module mem_load_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req_i,
  input  logic [31:0] ld_addr_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_signed_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] mdr_data_o,
  output logic        mdr_ena_o,
  output logic        busy_o,
  output logic        ld_done_o,
  output logic        ld_err_o
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_ERR} state_t;
  state_t state_q;
  logic [1:0] lo_q, size_q;
  logic sgn_q, mem_rd_q, mdr_ena_q, busy_q, ld_done_q, ld_err_q;
  logic [31:0] mem_addr_q, mdr_data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0] byte_d;
  logic [15:0] half_d;
  logic [31:0] ext_d;
  logic bad_d;
  // lane selection and extension of the latched request against the incoming word; alignment check of a new request
  always_comb begin
    byte_d = lo_q[1] ? (lo_q[0] ? mem_rdata_i[31:24] : mem_rdata_i[23:16]) : (lo_q[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0]);
    half_d = lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ext_d = size_q == 2'b10 ? mem_rdata_i : size_q == 2'b01 ? {{16{sgn_q & half_d[15]}}, half_d} : {{24{sgn_q & byte_d[7]}}, byte_d};
    bad_d = ld_size_i == 2'b11 || (ld_size_i == 2'b01 && ld_addr_i[0]) || (ld_size_i == 2'b10 && ld_addr_i[1:0] != 2'b00);
  end
  // load sequencer; every output is a register updated alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q <= '0;
      size_q <= '0;
      sgn_q <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_addr_q <= '0;
      mdr_data_q <= '0;
      mdr_ena_q <= 1'b0;
      busy_q <= 1'b0;
      ld_done_q <= 1'b0;
      ld_err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (ld_req_i) begin
          lo_q <= ld_addr_i[1:0];
          size_q <= ld_size_i;
          sgn_q <= ld_signed_i;
          mem_addr_q <= {ld_addr_i[31:2], 2'b00};
          busy_q <= 1'b1;
          state_q <= bad_d ? S_ERR : S_REQ;
          ld_err_q <= bad_d;
          mem_rd_q <= !bad_d;
        end
        S_REQ: begin
          state_q <= S_WAIT;
          cnt_q <= '0;
        end
        S_WAIT: if (mem_ack_i) begin
          state_q <= S_WRITE;
          mdr_data_q <= ext_d;
          mem_rd_q <= 1'b0;
          mdr_ena_q <= 1'b1;
          ld_done_q <= 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_q <= S_ERR;
          mem_rd_q <= 1'b0;
          ld_err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          mdr_ena_q <= 1'b0;
          ld_done_q <= 1'b0;
          ld_err_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
  assign mem_rd_o = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign mdr_data_o = mdr_data_q;
  assign mdr_ena_o = mdr_ena_q;
  assign busy_o = busy_q;
  assign ld_done_o = ld_done_q;
  assign ld_err_o = ld_err_q;
endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed and random loads checked against an arithmetic reference model
module tb_mem_load_unit;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1, ld_req = 1'b0, ld_signed = 1'b0, mem_ack = 1'b0;
  logic [31:0] ld_addr = '0, mem_rdata = '0;
  logic [1:0] ld_size = '0;
  logic mem_rd, mdr_ena, busy, ld_done, ld_err;
  logic [31:0] mem_addr, mdr_data;
  int total = 0, bad = 0;
  logic [31:0] last_mdr = '0;
  mem_load_unit #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_size_i(ld_size),
    .ld_signed_i(ld_signed), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack),
    .mem_rdata_i(mem_rdata), .mdr_data_o(mdr_data), .mdr_ena_o(mdr_ena), .busy_o(busy),
    .ld_done_o(ld_done), .ld_err_o(ld_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'b11) return 1'b0;
    return (a % (32'd1 << s)) == 0;
  endfunction
  function automatic logic [31:0] model(input logic [31:0] a, input logic [1:0] s, input bit sg, input logic [31:0] r);
    longint n, v;
    n = longint'(1) << s;
    if (n == 4) return r;
    v = (longint'(r) >> (8 * (a % 4))) % (longint'(1) << (8 * n));
    if (sg && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction
  task automatic outs_idle(input string tag);
    chk({tag, ".rd"}, 32'(mem_rd), 0);
    chk({tag, ".ena"}, 32'(mdr_ena), 0);
    chk({tag, ".done"}, 32'(ld_done), 0);
    chk({tag, ".err"}, 32'(ld_err), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] s, input bit sg,
                         input logic [31:0] r, input int dly);
    ld_req = 1'b1; ld_addr = a; ld_size = s; ld_signed = sg;
    cyc();
    ld_req = 1'b0; ld_addr = $urandom; ld_size = 2'($urandom); ld_signed = 1'($urandom);
    if (!legal(a, s)) begin
      chk({tag, ".err"}, 32'(ld_err), 1);
      chk({tag, ".rd"}, 32'(mem_rd), 0);
      chk({tag, ".busy"}, 32'(busy), 1);
      cyc();
      chk({tag, ".mdr"}, mdr_data, last_mdr);
      outs_idle({tag, ".after"});
      return;
    end
    chk({tag, ".rd"}, 32'(mem_rd), 1);
    chk({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = $urandom;
    cyc();
    mem_ack = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk({tag, ".wait"}, {30'd0, mem_rd, ld_err}, 32'd2);
      cyc();
    end
    mem_ack = 1'b1; mem_rdata = r;
    cyc();
    mem_ack = 1'b0; mem_rdata = $urandom;
    last_mdr = model(a, s, sg, r);
    chk({tag, ".ena"}, {29'd0, mdr_ena, ld_done, ld_err}, 32'd6);
    chk({tag, ".mdr"}, mdr_data, last_mdr);
    chk({tag, ".rd_low"}, 32'(mem_rd), 0);
    cyc();
    chk({tag, ".mdr_hold"}, mdr_data, last_mdr);
    outs_idle({tag, ".after"});
  endtask
  initial begin
    #3;
    outs_idle("reset");
    chk("reset.mdr", mdr_data, 0);
    chk("reset.addr", mem_addr, 0);
    cyc();
    rst = 1'b0;
    cyc();
    do_load("lw", 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 2);
    do_load("lb", 32'h103, 2'b00, 1'b1, 32'h80123456, 0);
    chk("lb.ref", last_mdr, 32'hFFFFFF80);
    do_load("lbu", 32'h103, 2'b00, 1'b0, 32'h80123456, 1);
    chk("lbu.ref", last_mdr, 32'h00000080);
    do_load("lh", 32'h102, 2'b01, 1'b1, 32'h80017FFF, 0);
    chk("lh.ref", last_mdr, 32'hFFFF8001);
    do_load("lhu", 32'h100, 2'b01, 1'b0, 32'h80017FFF, 3);
    chk("lhu.ref", last_mdr, 32'h00007FFF);
    do_load("lw_mis", 32'h102, 2'b10, 1'b0, 32'h0, 0);
    do_load("ill", 32'h100, 2'b11, 1'b1, 32'h0, 0);
    do_load("lh_mis", 32'h101, 2'b01, 1'b1, 32'h0, 0);
    ld_req = 1'b1; ld_addr = 32'h200; ld_size = 2'b10;
    cyc();
    ld_req = 1'b0;
    cyc();
    for (int i = 0; i < TO; i++) begin
      chk("to.wait", {30'd0, mem_rd, ld_err}, 32'd2);
      cyc();
    end
    chk("to.err", 32'(ld_err), 1);
    chk("to.rd", 32'(mem_rd), 0);
    chk("to.mdr", mdr_data, last_mdr);
    cyc();
    outs_idle("to.after");
    do_load("to_last", 32'h204, 2'b10, 1'b0, 32'h12345678, TO - 1);
    ld_req = 1'b1; ld_addr = 32'h300; ld_size = 2'b10;
    cyc();
    ld_req = 1'b0;
    cyc();
    cyc();
    chk("rst.pre_rd", 32'(mem_rd), 1);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    outs_idle("rst.async");
    chk("rst.mdr", mdr_data, 0);
    chk("rst.addr", mem_addr, 0);
    last_mdr = '0;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    mem_ack = 1'b0;
    outs_idle("rst.late_ack");
    chk("rst.late_mdr", mdr_data, 0);
    do_load("post_rst", 32'h304, 2'b10, 1'b0, 32'hA5A55A5A, 0);
    ld_req = 1'b1; ld_addr = 32'h400; ld_size = 2'b10;
    cyc();
    ld_addr = 32'h500;
    cyc();
    ld_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BADCAFE;
    cyc();
    mem_ack = 1'b0;
    chk("busy_ign.addr", mem_addr, 32'h400);
    last_mdr = 32'h0BADCAFE;
    chk("busy_ign.mdr", mdr_data, last_mdr);
    cyc();
    cyc();
    outs_idle("busy_ign.after");
    for (int k = 0; k < 40; k++)
      do_load("rnd", $urandom, 2'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 4)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
